// File: rtl/muler_seq.sv
`default_nettype none
// ============================================================================
// Module   : muler_seq
// Brief    : Sequential 16x16 shift-add multiplier, one multiplier bit per
//            clock, registered 32-bit product with a one-cycle done strobe.
//            Optional two's-complement operands: define MULER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module muler_seq (
    input  logic        CK,
    input  logic        RST_N,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        start,
    output logic [31:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [15:0] acc_hi;
    logic [4:0]  cnt;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [16:0] sum;
    logic [15:0] acc_nxt;
    logic [15:0] mplier_nxt;
    logic [31:0] result;
    logic [31:0] prod_nxt;

`ifdef MULER_SIGNED_EN
    logic sgn;

    // Core works on magnitudes; 0x8000 maps to 32768, which still fits 16 bits.
    always_comb begin
        op_a     = in1[15] ? (~in1) + 16'd1 : in1;
        op_b     = in2[15] ? (~in2) + 16'd1 : in2;
        prod_nxt = sgn ? (~result) + 32'd1 : result;
    end
`else
    always_comb begin
        op_a     = in1;
        op_b     = in2;
        prod_nxt = result;
    end
`endif

    // The multiplier register doubles as the low half of the accumulator:
    // each shift retires one multiplier bit and admits one product bit.
    always_comb begin
        sum        = mplier[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        acc_nxt    = sum[16:1];
        mplier_nxt = {sum[0], mplier[15:1]};
        result     = {acc_nxt, mplier_nxt};
    end

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state   <= IDLE;
            mcand   <= 16'd0;
            mplier  <= 16'd0;
            acc_hi  <= 16'd0;
            cnt     <= 5'd0;
            product <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MULER_SIGNED_EN
            sgn     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc_hi <= 16'd0;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef MULER_SIGNED_EN
                        sgn    <= in1[15] ^ in2[15];
`endif
                    end
                end
                RUN: begin
                    acc_hi <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 5'd1;
                    // cnt==15 here means this edge performs the 16th iteration
                    if (cnt == 5'd15) begin
                        product <= prod_nxt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
